// File: rtl/axi_lite_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_rd_arbiter
//
// Purpose:
//   Shares the single AXI-lite read port of the data memory between the
//   instruction fetch unit (IFU) and the load/store unit (LSU). Only one read
//   is in flight at a time. Ties are broken round-robin. The grant is held
//   from the AR handshake through the R handshake. Write channels do not pass
//   through this block.
//
// Ports:
//   i_clk, i_rst_n        clock and synchronous active-low reset
//   ifu_ar*/ifu_r*        IFU read master (AR in, R out)
//   lsu_ar*/lsu_r*        LSU read master (AR in, R out)
//   araddr/arvalid/arready, rdata/rresp/rvalid/rready
//                         slave-side AXI-lite read channels
//   o_grant               one-hot owner: bit0 = IFU, bit1 = LSU, 00 = idle
// ---------------------------------------------------------------------------
module axi_lite_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // IFU read master
  input  logic [ADDR_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  // LSU read master
  input  logic [ADDR_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  // Slave side
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  // Current owner
  output logic [1:0]            o_grant
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AR_IFU = 3'd1,
    R_IFU  = 3'd2,
    AR_LSU = 3'd3,
    R_LSU  = 3'd4
  } state_e;

  state_e state_q, state_d;
  // Owner of the most recent AR handshake: 0 = IFU, 1 = LSU.
  logic   last_grant_q, last_grant_d;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (ifu_arvalid && lsu_arvalid) begin
          // Tie: favour whichever master did not win last time.
          state_d = last_grant_q ? AR_IFU : AR_LSU;
        end else if (ifu_arvalid) begin
          state_d = AR_IFU;
        end else if (lsu_arvalid) begin
          state_d = AR_LSU;
        end
      end
      AR_IFU: begin
        // A master dropping arvalid here simply parks the arbiter in AR_IFU.
        if (ifu_arvalid && arready) begin
          state_d      = R_IFU;
          last_grant_d = 1'b0;
        end
      end
      R_IFU: begin
        if (rvalid && ifu_rready) state_d = IDLE;
      end
      AR_LSU: begin
        if (lsu_arvalid && arready) begin
          state_d      = R_LSU;
          last_grant_d = 1'b1;
        end
      end
      R_LSU: begin
        if (rvalid && lsu_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode: every output is a function of state plus the pass-through
  // signals of the current owner, so nothing leaks while idle.
  // -------------------------------------------------------------------------
  always_comb begin
    araddr      = '0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = 2'b00;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = 2'b00;
    lsu_rvalid  = 1'b0;
    o_grant     = 2'b00;
    unique case (state_q)
      AR_IFU: begin
        araddr      = ifu_araddr;
        arvalid     = ifu_arvalid;
        ifu_arready = arready;
        o_grant     = 2'b01;
      end
      R_IFU: begin
        ifu_rdata  = rdata;
        ifu_rresp  = rresp;
        ifu_rvalid = rvalid;
        rready     = ifu_rready;
        o_grant    = 2'b01;
      end
      AR_LSU: begin
        araddr      = lsu_araddr;
        arvalid     = lsu_arvalid;
        lsu_arready = arready;
        o_grant     = 2'b10;
      end
      R_LSU: begin
        lsu_rdata  = rdata;
        lsu_rresp  = rresp;
        lsu_rvalid = rvalid;
        rready     = lsu_rready;
        o_grant    = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
module tb_axi_lite_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [AW-1:0] ifu_araddr;
  logic          ifu_arvalid;
  logic          ifu_arready;
  logic [DW-1:0] ifu_rdata;
  logic [1:0]    ifu_rresp;
  logic          ifu_rvalid;
  logic          ifu_rready;
  logic [AW-1:0] lsu_araddr;
  logic          lsu_arvalid;
  logic          lsu_arready;
  logic [DW-1:0] lsu_rdata;
  logic [1:0]    lsu_rresp;
  logic          lsu_rvalid;
  logic          lsu_rready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [1:0]    o_grant;

  int tests_run    = 0;
  int tests_failed = 0;

  axi_lite_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .ifu_araddr  (ifu_araddr),
    .ifu_arvalid (ifu_arvalid),
    .ifu_arready (ifu_arready),
    .ifu_rdata   (ifu_rdata),
    .ifu_rresp   (ifu_rresp),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rready  (ifu_rready),
    .lsu_araddr  (lsu_araddr),
    .lsu_arvalid (lsu_arvalid),
    .lsu_arready (lsu_arready),
    .lsu_rdata   (lsu_rdata),
    .lsu_rresp   (lsu_rresp),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_rready  (lsu_rready),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .o_grant     (o_grant)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst_n     = 1'b0;
    ifu_araddr  = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
    lsu_araddr  = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
    arready     = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Drive the slave R channel so a leaky decode would show up.
    apply_reset();
    rdata = 32'hFFFF_FFFF; rresp = 2'b11; rvalid = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
    #1;
    tests_run++;
    if ({arvalid, rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, o_grant} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {arvalid, rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, o_grant});
    end
    tests_run++;
    if ({araddr, ifu_rdata, lsu_rdata, ifu_rresp, lsu_rresp} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: araddr=%h ifu_rdata=%h lsu_rdata=%h rresp=%b/%b expected zeros",
               araddr, ifu_rdata, lsu_rdata, ifu_rresp, lsu_rresp);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_ifu_only();
    apply_reset();
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1; arready = 1'b1; ifu_rready = 1'b1;
    #1;
    tests_run++;
    if (o_grant !== 2'b00 || arvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ifu_idle: grant=%b arvalid=%b expected 00/0", o_grant, arvalid);
    end
    tick(); // AR_IFU
    tests_run++;
    if (o_grant !== 2'b01 || arvalid !== 1'b1 || araddr !== 32'h8000_0000 ||
        ifu_arready !== 1'b1 || lsu_arready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ifu_ar: grant=%b arvalid=%b araddr=%h arready i/l=%b%b expected 01/1/80000000/10",
               o_grant, arvalid, araddr, ifu_arready, lsu_arready);
    end
    tick(); // R_IFU, slave not yet responding
    ifu_arvalid = 1'b0; arready = 1'b0;
    #1;
    tests_run++;
    if (o_grant !== 2'b01 || arvalid !== 1'b0 || ifu_rvalid !== 1'b0 || rready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ifu_r_wait: grant=%b arvalid=%b ifu_rvalid=%b rready=%b expected 01/0/0/1",
               o_grant, arvalid, ifu_rvalid, rready);
    end
    tick(); // R_IFU, response arrives
    rvalid = 1'b1; rdata = 32'h0000_0413; rresp = 2'b00;
    #1;
    tests_run++;
    if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || lsu_rvalid !== 1'b0 || o_grant !== 2'b01) begin
      tests_failed++;
      $display("FAIL ifu_r_data: rvalid=%b rdata=%h lsu_rvalid=%b grant=%b expected 1/00000413/0/01",
               ifu_rvalid, ifu_rdata, lsu_rvalid, o_grant);
    end
    tick(); // IDLE
    rvalid = 1'b0;
    #1;
    tests_run++;
    if (o_grant !== 2'b00 || ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ifu_done: grant=%b ifu_rvalid=%b lsu_rvalid=%b expected 00/0/0",
               o_grant, ifu_rvalid, lsu_rvalid);
    end
    $display("[TB] test_ifu_only done");
  endtask

  task automatic test_tie_after_reset();
    apply_reset();
    ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_1000; lsu_arvalid = 1'b1;
    arready = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
    tick(); // AR_LSU
    tests_run++;
    if (o_grant !== 2'b10 || araddr !== 32'h8000_1000 || lsu_arready !== 1'b1 || ifu_arready !== 1'b0) begin
      tests_failed++;
      $display("FAIL tie_first: grant=%b araddr=%h arready i/l=%b%b expected 10/80001000/01",
               o_grant, araddr, ifu_arready, lsu_arready);
    end
    tick(); // R_LSU
    lsu_arvalid = 1'b0; arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
    #1;
    tests_run++;
    if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h1234_5678 || ifu_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL tie_lsu_r: lsu_rvalid=%b lsu_rdata=%h ifu_rvalid=%b expected 1/12345678/0",
               lsu_rvalid, lsu_rdata, ifu_rvalid);
    end
    tick(); // IDLE
    rvalid = 1'b0;
    #1;
    tests_run++;
    if (o_grant !== 2'b00) begin
      tests_failed++;
      $display("FAIL tie_gap: grant=%b expected 00", o_grant);
    end
    tick(); // AR_IFU
    tests_run++;
    if (o_grant !== 2'b01 || araddr !== 32'h8000_0004) begin
      tests_failed++;
      $display("FAIL tie_second: grant=%b araddr=%h expected 01/80000004", o_grant, araddr);
    end
    ifu_arvalid = 1'b0;
    $display("[TB] test_tie_after_reset done");
  endtask

  task automatic test_back_to_back();
    logic [1:0]    exp_grant;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] got_data;
    logic          got_valid;
    apply_reset();
    ifu_araddr = 32'h8000_0100; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_2000; lsu_arvalid = 1'b1;
    arready = 1'b1; rvalid = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_grant = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_addr  = (i % 2 == 0) ? 32'h8000_2000 : 32'h8000_0100;
      rdata     = 32'hD000_0000 + i;
      tick(); // AR
      tests_run++;
      if (o_grant !== exp_grant || araddr !== exp_addr) begin
        tests_failed++;
        $display("FAIL b2b_ar[%0d]: grant=%b araddr=%h expected %b/%h", i, o_grant, araddr, exp_grant, exp_addr);
      end
      tick(); // R
      got_data  = (exp_grant == 2'b10) ? lsu_rdata : ifu_rdata;
      got_valid = (exp_grant == 2'b10) ? lsu_rvalid : ifu_rvalid;
      tests_run++;
      if (o_grant !== exp_grant || got_valid !== 1'b1 || got_data !== 32'hD000_0000 + i) begin
        tests_failed++;
        $display("FAIL b2b_r[%0d]: grant=%b rvalid=%b rdata=%h expected %b/1/%h",
                 i, o_grant, got_valid, got_data, exp_grant, 32'hD000_0000 + i);
      end
      tick(); // IDLE
      tests_run++;
      if (o_grant !== 2'b00 || rready !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_idle[%0d]: grant=%b rready=%b expected 00/0", i, o_grant, rready);
      end
      $display("[TB] b2b txn %0d grant=%b", i, o_grant);
    end
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; rvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    ifu_araddr = 32'h8000_0040; ifu_arvalid = 1'b1;
    tick(); // AR_IFU, slave stalls
    lsu_araddr = 32'h8000_3000; lsu_arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (o_grant !== 2'b01 || arvalid !== 1'b1 || ifu_arready !== 1'b0 || lsu_arready !== 1'b0 ||
          araddr !== 32'h8000_0040) begin
        tests_failed++;
        $display("FAIL bp_ar[%0d]: grant=%b arvalid=%b arready i/l=%b%b araddr=%h expected 01/1/00/80000040",
                 i, o_grant, arvalid, ifu_arready, lsu_arready, araddr);
      end
      tick();
    end
    arready = 1'b1;
    tick(); // R_IFU, master stalls
    ifu_arvalid = 1'b0; arready = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_F00D; ifu_rready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (o_grant !== 2'b01 || rready !== 1'b0 || ifu_rvalid !== 1'b1 || lsu_arready !== 1'b0 ||
          lsu_rvalid !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_r[%0d]: grant=%b rready=%b ifu_rvalid=%b lsu_arready=%b lsu_rvalid=%b expected 01/0/1/0/0",
                 i, o_grant, rready, ifu_rvalid, lsu_arready, lsu_rvalid);
      end
      tick();
    end
    ifu_rready = 1'b1;
    #1;
    tests_run++;
    if (rready !== 1'b1 || o_grant !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_release: rready=%b grant=%b expected 1/01", rready, o_grant);
    end
    tick(); // IDLE
    rvalid = 1'b0; lsu_arvalid = 1'b0;
    #1;
    tests_run++;
    if (o_grant !== 2'b00) begin
      tests_failed++;
      $display("FAIL bp_done: grant=%b expected 00", o_grant);
    end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_reset_mid_r();
    apply_reset();
    lsu_araddr = 32'h8000_4000; lsu_arvalid = 1'b1; arready = 1'b1; lsu_rready = 1'b1;
    tick(); // AR_LSU
    tick(); // R_LSU, no response yet
    lsu_arvalid = 1'b0; arready = 1'b0;
    #1;
    tests_run++;
    if (o_grant !== 2'b10) begin
      tests_failed++;
      $display("FAIL mid_pre: grant=%b expected 10", o_grant);
    end
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    #1;
    tests_run++;
    if (o_grant !== 2'b00 || rready !== 1'b0 || arvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: grant=%b rready=%b arvalid=%b expected 00/0/0", o_grant, rready, arvalid);
    end
    rvalid = 1'b1; rdata = 32'hCAFE_0001; ifu_rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (lsu_rvalid !== 1'b0 || ifu_rvalid !== 1'b0 || rready !== 1'b0 || o_grant !== 2'b00) begin
        tests_failed++;
        $display("FAIL mid_late_r[%0d]: lsu_rvalid=%b ifu_rvalid=%b rready=%b grant=%b expected 0/0/0/00",
                 i, lsu_rvalid, ifu_rvalid, rready, o_grant);
      end
      tick();
    end
    rvalid = 1'b0;
    ifu_araddr = 32'h8000_0008; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_5000; lsu_arvalid = 1'b1;
    tick(); // tie resolves with last_grant cleared
    tests_run++;
    if (o_grant !== 2'b10 || araddr !== 32'h8000_5000) begin
      tests_failed++;
      $display("FAIL mid_tie: grant=%b araddr=%h expected 10/80005000", o_grant, araddr);
    end
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    $display("[TB] test_reset_mid_r done");
  endtask

  task automatic test_error_resp();
    apply_reset();
    ifu_araddr = 32'h8000_0FF0; ifu_arvalid = 1'b1; arready = 1'b1; ifu_rready = 1'b1;
    tick(); // AR_IFU
    tick(); // R_IFU
    ifu_arvalid = 1'b0; arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata = 32'h0;
    #1;
    tests_run++;
    if (ifu_rresp !== 2'b10 || ifu_rvalid !== 1'b1 || lsu_rresp !== 2'b00) begin
      tests_failed++;
      $display("FAIL err_resp: ifu_rresp=%b ifu_rvalid=%b lsu_rresp=%b expected 10/1/00",
               ifu_rresp, ifu_rvalid, lsu_rresp);
    end
    tick(); // IDLE
    rvalid = 1'b0;
    #1;
    tests_run++;
    if (o_grant !== 2'b00 || ifu_rresp !== 2'b00) begin
      tests_failed++;
      $display("FAIL err_idle: grant=%b ifu_rresp=%b expected 00/00", o_grant, ifu_rresp);
    end
    $display("[TB] test_error_resp done");
  endtask

  initial begin
    test_reset();
    test_ifu_only();
    test_tie_after_reset();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_r();
    test_error_resp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
